// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   PC generator and fetch stage in front of the L1 instruction cache.
//   Keeps at most one word request outstanding. Returned words are buffered
//   together with their PCs in a small FIFO and handed to decode over a
//   valid/ready handshake. A redirect (branch/jump/trap) flushes the FIFO and
//   causes any in-flight response to be discarded.
//
// Ports
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   icache_req_o       one-cycle request pulse to the I-cache
//   icache_addr_o      fetch address, held from the request until the next one
//   icache_rvalid_i    one-cycle response strobe
//   icache_rdata_i     instruction word, qualified by icache_rvalid_i
//   redirect_valid_i   redirect fetch to redirect_pc_i this cycle
//   redirect_pc_i      new PC; bits [1:0] are forced to zero
//   out_valid_o        FIFO head holds an instruction
//   out_ready_i        decode takes the head this cycle
//   out_instr_o        head instruction (0 when empty)
//   out_pc_o           PC of the head instruction (0 when empty)
//   fetch_state_o      debug: 0=IDLE 1=WAIT 2=DROP
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_rvalid_i,
    input  logic [31:0] icache_rdata_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic [1:0]  fetch_state_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;

    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   mem_pc    [FIFO_DEPTH];
    logic [31:0]   mem_instr [FIFO_DEPTH];

    logic          push, pop, flush, rsp;
    logic [31:0]   redir_pc;

    assign redir_pc = {redirect_pc_i[31:2], 2'b00};
    // The cache cannot answer in the cycle the request is presented, so a
    // strobe coinciding with the request pulse is not a response.
    assign rsp      = icache_rvalid_i & ~req_q;

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = 1'b0;
        addr_d  = addr_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A response strobe here is a protocol error and is ignored.
                if (redirect_valid_i) begin
                    pc_d  = redir_pc;
                    flush = 1'b1;
                end else if (count_q < CW'(FIFO_DEPTH)) begin
                    // Space is reserved at issue time, so the later push
                    // can never overflow the buffer.
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid_i) begin
                    pc_d    = redir_pc;
                    flush   = 1'b1;
                    // Still outstanding: the stale word must be swallowed.
                    state_d = rsp ? S_IDLE : S_DROP;
                end else if (rsp) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (redirect_valid_i) begin
                    pc_d  = redir_pc;
                    flush = 1'b1;
                end
                if (rsp) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer
    // ------------------------------------------------------------------
    assign out_valid_o = (count_q != '0);
    // Flush wins: a pop in the redirect cycle is lost with everything else.
    assign pop         = out_valid_o & out_ready_i & ~flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_pc[wptr_q]    <= pc_q;
            mem_instr[wptr_q] <= icache_rdata_i;
        end
    end

    assign out_instr_o   = out_valid_o ? mem_instr[rptr_q] : 32'h0;
    assign out_pc_o      = out_valid_o ? mem_pc[rptr_q]    : 32'h0;
    assign icache_req_o  = req_q;
    assign icache_addr_o = addr_q;
    assign fetch_state_o = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [1:0] I = 2'd0, W = 2'd1, D = 2'd2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_rvalid;
    logic [31:0] icache_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  fetch_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .icache_req_o     (icache_req),
        .icache_addr_o    (icache_addr),
        .icache_rvalid_i  (icache_rvalid),
        .icache_rdata_i   (icache_rdata),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_instr_o      (out_instr),
        .out_pc_o         (out_pc),
        .fetch_state_o    (fetch_state)
    );

    // Inputs to drive for the coming edge, plus outputs expected now
    // (i.e. as left by the previous edge).
    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        ordy;
        logic        redir;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eov;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [1:0]  est;
    } vec_t;

    function automatic vec_t mk(logic rv, logic [31:0] rd, logic ordy, logic redir,
                                logic [31:0] rpc, logic ereq, logic [31:0] eaddr,
                                logic eov, logic [31:0] epc, logic [31:0] einstr,
                                logic [1:0] est);
        vec_t v;
        v.rv = rv; v.rd = rd; v.ordy = ordy; v.redir = redir; v.rpc = rpc;
        v.ereq = ereq; v.eaddr = eaddr; v.eov = eov; v.epc = epc;
        v.einstr = einstr; v.est = est;
        return v;
    endfunction

    task automatic chk(input vec_t v, input string tag);
        n_vec++;
        if (icache_req !== v.ereq || icache_addr !== v.eaddr || out_valid !== v.eov ||
            out_pc !== v.epc || out_instr !== v.einstr || fetch_state !== v.est) begin
            n_err++;
            $display("FAIL %s: got req=%0b addr=%h ov=%0b pc=%h instr=%h st=%0d, expected req=%0b addr=%h ov=%0b pc=%h instr=%h st=%0d",
                     tag, icache_req, icache_addr, out_valid, out_pc, out_instr, fetch_state,
                     v.ereq, v.eaddr, v.eov, v.epc, v.einstr, v.est);
        end
    endtask

    // Called on a falling edge: check, drive, advance to the next falling edge.
    task automatic av(input vec_t v, input string tag);
        chk(v, tag);
        icache_rvalid  = v.rv;
        icache_rdata   = v.rd;
        out_ready      = v.ordy;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        icache_rvalid  = 1'b0;
        icache_rdata   = 32'h0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    vec_t tbl [28];

    initial begin
        // T1: streaming fetch from 0x100, cache answers one cycle after req.
        tbl[0]  = mk(0, 32'h0,        1, 0, 0, 0, 32'h0,   0, 32'h0,   32'h0,        I);
        tbl[1]  = mk(0, 32'h0,        1, 0, 0, 1, 32'h100, 0, 32'h0,   32'h0,        W);
        tbl[2]  = mk(1, 32'h13,       1, 0, 0, 0, 32'h100, 0, 32'h0,   32'h0,        W);
        tbl[3]  = mk(0, 32'h0,        1, 0, 0, 0, 32'h100, 1, 32'h100, 32'h13,       I);
        tbl[4]  = mk(0, 32'h0,        1, 0, 0, 1, 32'h104, 0, 32'h0,   32'h0,        W);
        tbl[5]  = mk(1, 32'h00400093, 1, 0, 0, 0, 32'h104, 0, 32'h0,   32'h0,        W);
        tbl[6]  = mk(0, 32'h0,        1, 0, 0, 0, 32'h104, 1, 32'h104, 32'h00400093, I);
        tbl[7]  = mk(0, 32'h0,        1, 0, 0, 1, 32'h108, 0, 32'h0,   32'h0,        W);
        tbl[8]  = mk(1, 32'h13,       1, 0, 0, 0, 32'h108, 0, 32'h0,   32'h0,        W);
        tbl[9]  = mk(0, 32'h0,        1, 0, 0, 0, 32'h108, 1, 32'h108, 32'h13,       I);
        // T2: decode stalled, fill all four entries, no fifth request.
        tbl[10] = mk(0, 32'h0,  0, 0, 0, 1, 32'h10C, 0, 32'h0,   32'h0,  W);
        tbl[11] = mk(1, 32'hA0, 0, 0, 0, 0, 32'h10C, 0, 32'h0,   32'h0,  W);
        tbl[12] = mk(0, 32'h0,  0, 0, 0, 0, 32'h10C, 1, 32'h10C, 32'hA0, I);
        tbl[13] = mk(0, 32'h0,  0, 0, 0, 1, 32'h110, 1, 32'h10C, 32'hA0, W);
        tbl[14] = mk(1, 32'hA1, 0, 0, 0, 0, 32'h110, 1, 32'h10C, 32'hA0, W);
        tbl[15] = mk(0, 32'h0,  0, 0, 0, 0, 32'h110, 1, 32'h10C, 32'hA0, I);
        tbl[16] = mk(0, 32'h0,  0, 0, 0, 1, 32'h114, 1, 32'h10C, 32'hA0, W);
        tbl[17] = mk(1, 32'hA2, 0, 0, 0, 0, 32'h114, 1, 32'h10C, 32'hA0, W);
        tbl[18] = mk(0, 32'h0,  0, 0, 0, 0, 32'h114, 1, 32'h10C, 32'hA0, I);
        tbl[19] = mk(0, 32'h0,  0, 0, 0, 1, 32'h118, 1, 32'h10C, 32'hA0, W);
        tbl[20] = mk(1, 32'hA3, 0, 0, 0, 0, 32'h118, 1, 32'h10C, 32'hA0, W);
        tbl[21] = mk(0, 32'h0,  0, 0, 0, 0, 32'h118, 1, 32'h10C, 32'hA0, I);
        tbl[22] = mk(0, 32'h0,  0, 0, 0, 0, 32'h118, 1, 32'h10C, 32'hA0, I);
        tbl[23] = mk(0, 32'h0,  1, 0, 0, 0, 32'h118, 1, 32'h10C, 32'hA0, I);
        tbl[24] = mk(0, 32'h0,  0, 0, 0, 0, 32'h118, 1, 32'h110, 32'hA1, I);
        tbl[25] = mk(0, 32'h0,  0, 0, 0, 1, 32'h11C, 1, 32'h110, 32'hA1, W);
        tbl[26] = mk(1, 32'hA4, 0, 0, 0, 0, 32'h11C, 1, 32'h110, 32'hA1, W);
        tbl[27] = mk(0, 32'h0,  0, 0, 0, 0, 32'h11C, 1, 32'h110, 32'hA1, I);

        do_reset();
        for (int i = 0; i < 28; i++) av(tbl[i], $sformatf("tbl[%0d]", i));

        // T3: redirect to 0x2002 while waiting on 0x104 with a full-ish FIFO.
        do_reset();
        av(mk(0, 32'h0,        0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h0,  I), "T3.rst");
        av(mk(0, 32'h0,        0, 0, 32'h0,    1, 32'h100,  0, 32'h0,    32'h0,  W), "T3.req100");
        av(mk(1, 32'h13,       0, 0, 32'h0,    0, 32'h100,  0, 32'h0,    32'h0,  W), "T3.rsp100");
        av(mk(0, 32'h0,        0, 0, 32'h0,    0, 32'h100,  1, 32'h100,  32'h13, I), "T3.head");
        av(mk(0, 32'h0,        0, 0, 32'h0,    1, 32'h104,  1, 32'h100,  32'h13, W), "T3.req104");
        av(mk(0, 32'h0,        0, 1, 32'h2002, 0, 32'h104,  1, 32'h100,  32'h13, W), "T3.redir");
        av(mk(1, 32'hDEAD_BEEF,0, 0, 32'h0,    0, 32'h104,  0, 32'h0,    32'h0,  D), "T3.flushed");
        av(mk(0, 32'h0,        0, 0, 32'h0,    0, 32'h104,  0, 32'h0,    32'h0,  I), "T3.dropped");
        av(mk(0, 32'h0,        0, 0, 32'h0,    1, 32'h2000, 0, 32'h0,    32'h0,  W), "T3.req2000");
        av(mk(1, 32'h33,       0, 0, 32'h0,    0, 32'h2000, 0, 32'h0,    32'h0,  W), "T3.rsp2000");
        // T4: redirect in the same cycle as the response, with a pop attempt.
        av(mk(0, 32'h0,        0, 0, 32'h0,    0, 32'h2000, 1, 32'h2000, 32'h33, I), "T4.head");
        av(mk(0, 32'h0,        0, 0, 32'h0,    1, 32'h2004, 1, 32'h2000, 32'h33, W), "T4.req2004");
        av(mk(1, 32'hBAD,      1, 1, 32'h3000, 0, 32'h2004, 1, 32'h2000, 32'h33, W), "T4.collide");
        av(mk(0, 32'h0,        0, 0, 32'h0,    0, 32'h2004, 0, 32'h0,    32'h0,  I), "T4.flushed");
        av(mk(0, 32'h0,        0, 0, 32'h0,    1, 32'h3000, 0, 32'h0,    32'h0,  W), "T4.req3000");
        av(mk(1, 32'h44,       0, 0, 32'h0,    0, 32'h3000, 0, 32'h0,    32'h0,  W), "T4.rsp3000");
        // T5: redirect from IDLE to 0xFFFF_FFFF, then wrap to 0; stray rvalid in IDLE.
        av(mk(0, 32'h0,        0, 1, 32'hFFFF_FFFF, 0, 32'h3000, 1, 32'h3000, 32'h44, I), "T5.redir");
        av(mk(1, 32'h66,       0, 0, 32'h0,    0, 32'h3000, 0, 32'h0,    32'h0,  I), "T5.strayidle");
        av(mk(0, 32'h0,        0, 0, 32'h0,    1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, W), "T5.reqtop");
        av(mk(1, 32'h55,       0, 0, 32'h0,    0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, W), "T5.rsptop");
        av(mk(0, 32'h0,        1, 0, 32'h0,    0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h55, I), "T5.head");
        av(mk(0, 32'h0,        0, 0, 32'h0,    1, 32'h0,    0, 32'h0,    32'h0,  W), "T5.wrap");
        av(mk(1, 32'h88,       0, 0, 32'h0,    0, 32'h0,    0, 32'h0,    32'h0,  W), "T5.rsp0");
        av(mk(0, 32'h0,        0, 0, 32'h0,    0, 32'h0,    1, 32'h0,    32'h88, I), "T5.head0");
        av(mk(0, 32'h0,        0, 0, 32'h0,    1, 32'h4,    1, 32'h0,    32'h88, W), "T5.req4");
        av(mk(0, 32'h0,        0, 0, 32'h0,    0, 32'h4,    1, 32'h0,    32'h88, W), "T6.wait");

        // T6: asynchronous reset mid-request, then a late strobe after release.
        #2 rstn = 1'b0;
        #1 chk(mk(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, I), "T6.async");
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
        av(mk(1, 32'h77, 0, 0, 32'h0, 0, 32'h0,   0, 32'h0,   32'h0,  I), "T6.stray");
        av(mk(0, 32'h0,  0, 0, 32'h0, 1, 32'h100, 0, 32'h0,   32'h0,  W), "T6.req100");
        av(mk(1, 32'h99, 0, 0, 32'h0, 0, 32'h100, 0, 32'h0,   32'h0,  W), "T6.rsp100");
        av(mk(0, 32'h0,  0, 0, 32'h0, 0, 32'h100, 1, 32'h100, 32'h99, I), "T6.head");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
